// File: rtl/spi_capture_avalon_logger.sv
// SPI byte capture logger: synchronised SPI strobes feed a circular FIFO drained over Avalon-MM.
// Optional timestamp counter built when SPI_LOG_TIMESTAMP_EN is defined.
module spi_capture_avalon_logger #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 7,
  parameter int TS_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_InputBuffer,
  input  logic              io_BufferChanged,
  input  logic              io_ChipSelect,
  input  logic [ADDR_W-1:0] io_Avalon_address,
  input  logic              io_Avalon_read,
  input  logic              io_Avalon_write,
  input  logic [63:0]       io_Avalon_writedata,
  output logic [63:0]       io_Avalon_readdata,
  output logic              io_Avalon_readdatavalid
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W - 1;
  localparam int MEM_W = 1 + TS_W + DATA_W;

  typedef enum logic [1:0] {ST_DISABLED, ST_WAIT_FRAME, ST_IN_FRAME} state_t;

  state_t            state_q, state_d;
  logic [1:0]        chg_sync_q, chg_sync_d;
  logic [1:0]        cs_sync_q, cs_sync_d;
  logic              chg_prev_q, chg_prev_d;
  logic              enable_q, enable_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [TS_W-1:0]   ts_now;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              push, pop, clear, full, frame_flag, capture_evt, push_req;
  logic [IDX_W-1:0]  peek_idx;
  logic [PTR_W-1:0]  mem_idx;
  logic [MEM_W-1:0]  mem_rd;
  logic              unused_wdata;

  assign unused_wdata = ^io_Avalon_writedata[63:2];

`ifdef SPI_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  always_comb ts_d = ts_q + TS_W'(1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end
  assign ts_now = ts_q;
`else
  assign ts_now = '0;
`endif

  function automatic logic [63:0] fmt_entry(input logic [MEM_W-1:0] e);
    logic [63:0] r;
    r             = '0;
    r[63]         = 1'b1;
    r[62]         = e[MEM_W-1];
    r[16 +: TS_W] = e[DATA_W +: TS_W];
    r[0 +: DATA_W] = e[0 +: DATA_W];
    return r;
  endfunction

  // Pop and peek share one storage read port, selected by the address region.
  assign peek_idx = io_Avalon_address[IDX_W-1:0];
  assign mem_idx  = io_Avalon_address[ADDR_W-1] ? (rd_ptr_q + peek_idx[PTR_W-1:0]) : rd_ptr_q;
  assign mem_rd   = mem_q[mem_idx];

  always_comb begin
    chg_sync_d  = {chg_sync_q[0], io_BufferChanged};
    cs_sync_d   = {cs_sync_q[0], io_ChipSelect};
    chg_prev_d  = chg_sync_q[1];
    capture_evt = chg_sync_q[1] & ~chg_prev_q;

    clear    = io_Avalon_write && (io_Avalon_address == ADDR_W'(1)) && io_Avalon_writedata[1];
    enable_d = (io_Avalon_write && (io_Avalon_address == ADDR_W'(1))) ? io_Avalon_writedata[0] : enable_q;

    full       = (count_q == CNT_W'(DEPTH));
    pop        = io_Avalon_read && (io_Avalon_address == ADDR_W'(2)) && (count_q != '0);
    push_req   = capture_evt && (state_q != ST_DISABLED);
    push       = push_req && !clear && (!full || pop);
    frame_flag = (state_q == ST_WAIT_FRAME) && !cs_sync_q[1];

    case (state_q)
      ST_DISABLED:   state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: state_d = (push_req && !cs_sync_q[1]) ? ST_IN_FRAME : ST_WAIT_FRAME;
      ST_IN_FRAME:   state_d = cs_sync_q[1] ? ST_WAIT_FRAME : ST_IN_FRAME;
      default:       state_d = ST_DISABLED;
    endcase
    if (!enable_d) state_d = ST_DISABLED;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push_req && full && !pop) ovf_d = 1'b1;
    end

    // Read data is built from pre-write state and registered for a fixed one-cycle latency.
    rvalid_d = io_Avalon_read;
    rdata_d  = '0;
    if (io_Avalon_read) begin
      if (io_Avalon_address[ADDR_W-1]) begin
        if (32'(peek_idx) < 32'(count_q)) rdata_d = fmt_entry(mem_rd);
      end else if (io_Avalon_address == ADDR_W'(0)) begin
        rdata_d[CNT_W-1:0] = count_q;
        rdata_d[16]        = ovf_q;
        rdata_d[17]        = (count_q == '0);
        rdata_d[18]        = full;
      end else if (io_Avalon_address == ADDR_W'(1)) begin
        rdata_d[0] = enable_q;
      end else if (io_Avalon_address == ADDR_W'(2)) begin
        if (count_q != '0) rdata_d = fmt_entry(mem_rd);
      end else if (io_Avalon_address == ADDR_W'(3)) begin
        rdata_d[TS_W-1:0] = ts_now;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {frame_flag, ts_now, io_InputBuffer};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_DISABLED;
      chg_sync_q <= 2'b00;
      cs_sync_q  <= 2'b11;
      chg_prev_q <= 1'b0;
      enable_q   <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      chg_sync_q <= chg_sync_d;
      cs_sync_q  <= cs_sync_d;
      chg_prev_q <= chg_prev_d;
      enable_q   <= enable_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign io_Avalon_readdata      = rdata_q;
  assign io_Avalon_readdatavalid = rvalid_q;
endmodule

// File: tb/tb_spi_capture_avalon_logger.sv
// Directed bench for spi_capture_avalon_logger (DEPTH=4, ADDR_W=4, PEEK base 8).
module tb_spi_capture_avalon_logger;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int TS_W   = 32;
  localparam logic [63:0] ST_OVF   = 64'h1_0000;
  localparam logic [63:0] ST_EMPTY = 64'h2_0000;
  localparam logic [63:0] ST_FULL  = 64'h4_0000;
`ifdef SPI_LOG_TIMESTAMP_EN
  localparam logic [63:0] TS_MASK = 64'h0000_FFFF_FFFF_0000;
`else
  localparam logic [63:0] TS_MASK = 64'h0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] ib = '0;
  logic              chg = 1'b0;
  logic              cs = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              rd = 1'b0;
  logic              wr = 1'b0;
  logic [63:0]       wdata = '0;
  logic [63:0]       readdata;
  logic              rvalid;

  int tests_run = 0;
  int tests_failed = 0;

  spi_capture_avalon_logger #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
    .clock(clk), .reset(rst), .io_InputBuffer(ib), .io_BufferChanged(chg), .io_ChipSelect(cs),
    .io_Avalon_address(addr), .io_Avalon_read(rd), .io_Avalon_write(wr),
    .io_Avalon_writedata(wdata), .io_Avalon_readdata(readdata), .io_Avalon_readdatavalid(rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [63:0] ent(input logic f, input logic [7:0] d);
    return 64'h8000_0000_0000_0000 | (f ? 64'h4000_0000_0000_0000 : 64'h0) | {56'h0, d};
  endfunction

  task automatic av_read(input logic [ADDR_W-1:0] a, output logic [63:0] d);
    @(negedge clk); rd = 1'b1; addr = a;
    @(negedge clk); rd = 1'b0; d = readdata;
    check("rvalid", {63'b0, rvalid}, 64'd1);
  endtask

  task automatic av_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    @(negedge clk); wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr = 1'b0;
  endtask

  // Drives one byte; the optional Avalon op lands in the cycle the capture is written.
  task automatic send_op(input logic [7:0] b, input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [63:0] wd, output logic [63:0] d);
    @(negedge clk); ib = b; chg = 1'b1;
    @(negedge clk);
    @(negedge clk); rd = r; wr = w; addr = a; wdata = wd;
    @(negedge clk); rd = 1'b0; wr = 1'b0; d = readdata;
    @(negedge clk); chg = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [63:0] dummy;
    send_op(b, 1'b0, 1'b0, '0, 64'h0, dummy);
  endtask

  task automatic set_cs(input logic v);
    @(negedge clk); cs = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [63:0] exp);
    logic [63:0] d;
    av_read(4'd2, d);
    check(tag, d & ~TS_MASK, exp);
  endtask

  task automatic status_check(input string tag, input logic [63:0] exp);
    logic [63:0] d;
    av_read(4'd0, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [63:0] d, t0, t1;
    repeat (2) @(negedge clk);
    check("reset_rdata", readdata, 64'h0);
    check("reset_rvalid", {63'b0, rvalid}, 64'h0);
    rst = 1'b0;
    status_check("status_reset", ST_EMPTY);
    av_read(4'd1, d); check("ctrl_reset", d, 64'h0);

    send_byte(8'h55);
    status_check("disabled_ignored", ST_EMPTY);

    av_write(4'd1, 64'h1);
    av_read(4'd1, d); check("ctrl_enable", d, 64'h1);
    set_cs(1'b0);
    send_byte(8'h7A);
    send_byte(8'h80);
    status_check("status_two", 64'h2);
    pop_check("pop_7a", ent(1'b1, 8'h7A));
    pop_check("pop_80", ent(1'b0, 8'h80));
    pop_check("pop_empty", 64'h0);
    status_check("status_drained", ST_EMPTY);

    set_cs(1'b1); set_cs(1'b0);
    send_byte(8'h7A); send_byte(8'h80);
    set_cs(1'b1); set_cs(1'b0);
    send_byte(8'h0C); send_byte(8'h40);
    av_read(4'd8,  d); check("peek0", d & ~TS_MASK, ent(1'b1, 8'h7A));
    av_read(4'd9,  d); check("peek1", d & ~TS_MASK, ent(1'b0, 8'h80));
    av_read(4'd10, d); check("peek2", d & ~TS_MASK, ent(1'b1, 8'h0C));
    av_read(4'd11, d); check("peek3", d & ~TS_MASK, ent(1'b0, 8'h40));
    av_read(4'd12, d); check("peek4_beyond", d, 64'h0);
    status_check("status_full", ST_FULL | 64'h4);

    send_op(8'h11, 1'b1, 1'b0, 4'd2, 64'h0, d);
    check("pop_coincident", d & ~TS_MASK, ent(1'b1, 8'h7A));
    status_check("full_pop_capture", ST_FULL | 64'h4);

    send_byte(8'h99);
    status_check("overflow", ST_FULL | ST_OVF | 64'h4);
    pop_check("ovf_pop0", ent(1'b0, 8'h80));
    pop_check("ovf_pop1", ent(1'b1, 8'h0C));
    pop_check("ovf_pop2", ent(1'b0, 8'h40));
    pop_check("ovf_pop3", ent(1'b0, 8'h11));
    pop_check("ovf_pop_empty", 64'h0);
    status_check("ovf_sticky", ST_EMPTY | ST_OVF);

    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    status_check("three", ST_OVF | 64'h3);
    av_write(4'd1, 64'h3);
    status_check("cleared", ST_EMPTY);
    av_read(4'd1, d); check("ctrl_after_clear", d, 64'h1);
    @(negedge clk);
    check("rvalid_single", {63'b0, rvalid}, 64'h0);

    send_op(8'hC3, 1'b0, 1'b1, 4'd1, 64'h3, d);
    status_check("clear_wins", ST_EMPTY);

    send_byte(8'hB1);
    send_op(8'hB2, 1'b1, 1'b0, 4'd2, 64'h0, t0);
    check("pop_b1", t0 & ~TS_MASK, ent(1'b0, 8'hB1));
    status_check("capture_pop_one", 64'h1);
    av_read(4'd2, t1);
    check("pop_b2", t1 & ~TS_MASK, ent(1'b0, 8'hB2));

`ifdef SPI_LOG_TIMESTAMP_EN
    check("ts_increasing", {63'b0, (t1[47:16] > t0[47:16])}, 64'h1);
    @(negedge clk); rd = 1'b1; addr = 4'd3;
    @(negedge clk); d = readdata;
    @(negedge clk); rd = 1'b0;
    check("time_step", readdata - d, 64'h1);
`else
    av_read(4'd3, d); check("time_zero", d, 64'h0);
`endif

    send_byte(8'hE1);
    status_check("before_reset", 64'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midreset_rdata", readdata, 64'h0);
    rst = 1'b0;
    status_check("after_reset", ST_EMPTY);
    av_read(4'd1, d); check("ctrl_after_reset", d, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/spi_capture_avalon_logger.md
# spi_capture_avalon_logger

Parametrised successor to the single-byte SPI debug tap. It synchronises the SPI receiver's byte/changed strobe and chip-select into the system clock domain. Each received byte, with a frame-start flag and a free-running timestamp, is stored in a circular FIFO of configurable depth. The FIFO is exposed as an Avalon-MM slave with status, control, pop and non-destructive peek access, so a host can drain multi-frame SPI traffic after the fact.

## Interface
- DATA_W, 8, SPI byte width; 1..16
- DEPTH, 64, FIFO entries; power of two, 2..64
- ADDR_W, 7, Avalon word-address width; 2^(ADDR_W-1) ≥ DEPTH
- TS_W, 32, timestamp width; 1..46
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- io_InputBuffer  in  DATA_W  received byte from SPI receiver (SPI clock domain)
- io_BufferChanged  in  1  byte-complete strobe from SPI receiver (SPI clock domain)
- io_ChipSelect  in  1  SPI CS, active low (SPI pin domain)
- io_Avalon_address  in  ADDR_W  word address
- io_Avalon_read  in  1  read request
- io_Avalon_write  in  1  write request
- io_Avalon_writedata  in  64  write data
- io_Avalon_readdata  out  64  read data; 0 at reset
- io_Avalon_readdatavalid  out  1  read data valid; 0 at reset

## Operation
- Sync: io_BufferChanged and io_ChipSelect each pass through 2 flops. A rising edge of synced Changed = capture event; io_InputBuffer is sampled on that cycle.
- Capture FSM: DISABLED → WAIT_FRAME when CTRL.enable=1. WAIT_FRAME → IN_FRAME on a capture event while synced CS=0; that entry gets frame=1. IN_FRAME → WAIT_FRAME when synced CS=1. Any state → DISABLED when enable=0. Events in DISABLED are ignored.
- Entry format: [63] valid, [62] frame start, [16+TS_W-1:16] timestamp, [DATA_W-1:0] data, all else 0.
- Register map (word address):
  - 0 STATUS, read: [15:0] count, [16] overflow (sticky), [17] empty, [18] full.
  - 1 CTRL, read/write: [0] enable. Writing [1]=1 clears the FIFO and overflow; it is self-clearing and reads 0.
  - 2 POP, read: returns the oldest entry and removes it. When empty, returns all-zero (valid=0) and leaves the FIFO unchanged.
  - 3 TIME, read: current timestamp.
  - 2^(ADDR_W-1)+i PEEK: entry i from the oldest, with no side effect. Returns 0 if i ≥ count.
  - Other addresses read 0; writes to them are ignored.
- Full: a capture event is dropped and overflow is set. Exception: if a POP happens in the same cycle, the byte is accepted and count is unchanged.
- Capture and POP in the same cycle when not full: both take effect, so count is unchanged.
- Clear and capture in the same cycle: clear wins, the byte is dropped, and count=0.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Timestamp: TS_W-bit counter, increments every clock, wraps, reset to 0.
- Reset: FIFO empty, overflow=0, enable=0, FSM=DISABLED, sync flops=0 except CS sync=1, outputs 0.

## Timing
- Capture latency: the entry is visible in count 3 clocks after io_BufferChanged rises (2 sync + 1 write).
- Upstream must hold io_InputBuffer stable ≥4 clocks after Changed rises. Minimum spacing between capture events is 4 clocks.
- Read latency is fixed at 1: readdatavalid pulses exactly 1 cycle after read, with readdata valid in that cycle. Back-to-back reads are allowed every cycle.
- POP removal occurs in the read-request cycle. A POP on the next cycle returns the next entry.
- Writes take effect at the end of the write cycle. The first capture after enable can occur on the following clock.
- Read and write in the same cycle: the write is performed and the read returns pre-write state.
- Reset mid-operation discards all entries immediately.

## Configuration
- SPI_LOG_TIMESTAMP_EN defined: timestamp counter is built, entries carry the timestamp, and TIME returns the counter.
- SPI_LOG_TIMESTAMP_EN undefined: no counter is built, and the entry timestamp field and TIME read 0. All else is identical.

## Test plan
- Reset, enable, CS low, send bytes 0x7A, 0x80 → count=2. POP returns valid=1, frame=1, data 0x7A, then valid=1, frame=0, data 0x80. A third POP returns 0.
- 0x7A, 0x80, CS high 2 SPI clocks, then 0x0C, 0x40 → PEEK 0..3 gives frame flags 1,0,1,0 and data 7A,80,0C,40. count stays 4.
- DEPTH=4: send 5 bytes → status count=4, full=1, overflow=1. POPs return only the first 4 bytes.
- Full FIFO with POP coincident with a capture event → byte accepted, count stays 4, overflow stays 0.
- CTRL write 0x3 with 3 entries → count=0, empty=1, overflow=0, enable stays 1. Also check readdatavalid occurs exactly 1 cycle after every read.
- With SPI_LOG_TIMESTAMP_EN: entry timestamps are strictly increasing across captures 4+ clocks apart. Without it: timestamp field and TIME read 0.
